uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_sampler.sv | 47 ++++
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: parity mode
// constants, the receive FSM state type and the parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rxState_t;

    // Parity bit the line should carry, given the XOR of the data word.
    function automatic logic parityExpected(input logic dataXor, input int mode);
        return (mode == PAR_ODD) ? ~dataXor : dataXor;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop synchroniser for the serial line plus a 3-sample majority vote
// taken around the middle of each bit period.
module uart_bit_sampler #(
    parameter int CLKS_PER_BIT = 40,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             i_clk,
    input  logic             i_rstN,
    input  logic             i_rx,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_rxSync,
    output logic             o_strobe,
    output logic             o_bit
);

    localparam int HALF = CLKS_PER_BIT / 2;

    logic r_sync1;
    logic r_sync2;
    logic r_samp0;
    logic r_samp1;

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            if (i_cnt == CNT_W'(HALF - 1)) begin
                r_samp0 <= r_sync2;
            end
            if (i_cnt == CNT_W'(HALF)) begin
                r_samp1 <= r_sync2;
            end
        end
    end

    // The third sample is the live synchronised value, so the vote is
    // resolved in the same cycle the strobe is raised.
    assign o_rxSync = r_sync2;
    assign o_strobe = (i_cnt == CNT_W'(HALF + 1));
    assign o_bit    = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with ready/valid output holding, error flags
// and a sticky overrun indicator.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 40,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    rxState_t r_state;
    rxState_t w_next;

    logic [CNT_W-1:0]     r_bitCnt;
    logic [IDX_W-1:0]     r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_parErr;
    logic                 r_frameErr;
    logic                 r_overrun;
    logic                 r_parAcc;
    logic                 r_frameAcc;
    logic                 r_syncPrev;

    logic w_rxSync;
    logic w_strobe;
    logic w_bit;
    logic w_fall;
    logic w_bitEnd;
    logic w_lastData;
    logic w_lastStop;
    logic w_complete;

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_sampler (
        .i_clk    (clk),
        .i_rstN   (rst_n),
        .i_rx     (rx),
        .i_cnt    (r_bitCnt),
        .o_rxSync (w_rxSync),
        .o_strobe (w_strobe),
        .o_bit    (w_bit)
    );

    assign w_fall     = r_syncPrev & ~w_rxSync;
    assign w_bitEnd   = (r_bitCnt == CNT_MAX);
    assign w_lastData = (r_bitIdx == IDX_W'(DATA_BITS - 1));
    assign w_lastStop = (r_bitIdx == IDX_W'(STOP_BITS - 1));
    assign w_complete = (r_state == ST_STOP) && w_strobe && w_lastStop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (w_strobe && w_bit) begin
                    w_next = ST_IDLE;
                end else if (w_bitEnd) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bitEnd && w_lastData) begin
                    w_next = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_bitEnd) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at the final stop sample so the next start bit can be caught.
                if (w_strobe && w_lastStop) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_syncPrev <= 1'b1;
            r_bitCnt   <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_parAcc   <= 1'b0;
            r_frameAcc <= 1'b0;
        end else begin
            r_syncPrev <= w_rxSync;
            if (r_state == ST_IDLE) begin
                r_bitCnt   <= '0;
                r_bitIdx   <= '0;
                r_parAcc   <= 1'b0;
                r_frameAcc <= 1'b0;
            end else begin
                r_bitCnt <= w_bitEnd ? '0 : r_bitCnt + 1'b1;
                case (r_state)
                    ST_DATA: begin
                        if (w_strobe) begin
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        end
                        if (w_bitEnd) begin
                            r_bitIdx <= w_lastData ? '0 : r_bitIdx + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (w_strobe) begin
                            r_parAcc <= w_bit ^ parityExpected(^r_shift, PARITY);
                        end
                    end
                    ST_STOP: begin
                        if (w_strobe && !w_bit) begin
                            r_frameAcc <= 1'b1;
                        end
                        if (w_bitEnd) begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A finished frame lands only if the holding register is empty or being
    // emptied this cycle; otherwise it is dropped and overrun latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || rx_ready) begin
                r_data     <= r_shift;
                r_parErr   <= r_parAcc;
                r_frameErr <= r_frameAcc | ~w_bit;
                r_valid    <= 1'b1;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_parErr;
    assign frame_err  = r_frameErr;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances cover the default
// framing, even parity, and 7-bit data with two stop bits.
module tb_uart_rx_param;

    localparam int CPB = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rxLine    [3];
    logic readyLine [3];
    logic rstN      [3];

    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic valid0, valid1, valid2;
    logic pe0, pe1, pe2;
    logic fe0, fe1, fe2;
    logic ov0, ov1, ov2;
    logic busy0, busy1, busy2;

    int vecCount  = 0;
    int missCount = 0;

    int         validCycles = 0;
    int         hsCount     = 0;
    logic [7:0] hsData      = '0;
    logic       hsPe        = 1'b0;
    logic       hsFe        = 1'b0;

    uart_rx_param dut0 (
        .clk(clk), .rst_n(rstN[0]), .rx(rxLine[0]), .rx_data(data0),
        .rx_valid(valid0), .rx_ready(readyLine[0]), .parity_err(pe0),
        .frame_err(fe0), .overrun(ov0), .busy(busy0)
    );

    uart_rx_param #(.PARITY(1)) dut1 (
        .clk(clk), .rst_n(rstN[1]), .rx(rxLine[1]), .rx_data(data1),
        .rx_valid(valid1), .rx_ready(readyLine[1]), .parity_err(pe1),
        .frame_err(fe1), .overrun(ov1), .busy(busy1)
    );

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rstN[2]), .rx(rxLine[2]), .rx_data(data2),
        .rx_valid(valid2), .rx_ready(readyLine[2]), .parity_err(pe2),
        .frame_err(fe2), .overrun(ov2), .busy(busy2)
    );

    // Records every handshake on the default instance.
    always @(negedge clk) begin
        #1;
        if (valid0) validCycles <= validCycles + 1;
        if (valid0 && readyLine[0]) begin
            hsCount <= hsCount + 1;
            hsData  <= data0;
            hsPe    <= pe0;
            hsFe    <= fe0;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one frame on instance d, LSB first, optionally cut short.
    task automatic applyStimulus(input int d, input logic [8:0] data, input int nData,
                                 input int hasPar, input logic parBit, input int nStop,
                                 input logic [1:0] stopBits, input int maxCycles);
        logic [15:0] fr;
        int n;
        int cyc;
        fr = '1;
        fr[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nData; i++) begin
            fr[n] = data[i];
            n++;
        end
        if (hasPar != 0) begin
            fr[n] = parBit;
            n++;
        end
        for (int i = 0; i < nStop; i++) begin
            fr[n] = stopBits[i];
            n++;
        end
        cyc = 0;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (cyc >= maxCycles) return;
                @(negedge clk);
                rxLine[d] = fr[b];
                cyc++;
            end
        end
        @(negedge clk);
        rxLine[d] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int vcSnap;
    int hsSnap;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rxLine[i]    = 1'b1;
            readyLine[i] = 1'b0;
            rstN[i]      = 1'b0;
        end
        idle(4);
        checkOutput("reset_valid",   {15'd0, valid0}, 16'd0);
        checkOutput("reset_busy",    {15'd0, busy0},  16'd0);
        checkOutput("reset_data",    {8'd0, data0},   16'd0);
        checkOutput("reset_flags",   {13'd0, pe0, fe0, ov0}, 16'd0);
        for (int i = 0; i < 3; i++) rstN[i] = 1'b1;
        idle(20);

        // Single word with the consumer always ready.
        readyLine[0] = 1'b1;
        vcSnap = validCycles;
        hsSnap = hsCount;
        applyStimulus(0, 9'h038, 8, 0, 1'b0, 1, 2'b11, 100000);
        idle(CPB);
        checkOutput("t1_valid_cycles", 16'(validCycles - vcSnap), 16'd1);
        checkOutput("t1_hs_count",     16'(hsCount - hsSnap),     16'd1);
        checkOutput("t1_data",         {8'd0, hsData}, 16'h0038);
        checkOutput("t1_flags",        {14'd0, hsPe, hsFe}, 16'd0);

        // Framing error is delivered, then a clean word clears it.
        applyStimulus(0, 9'h02A, 8, 0, 1'b0, 1, 2'b00, 100000);
        idle(CPB);
        checkOutput("t2_bad_data", {8'd0, hsData}, 16'h002A);
        checkOutput("t2_bad_fe",   {15'd0, hsFe},  16'd1);
        idle(2 * CPB);
        applyStimulus(0, 9'h039, 8, 0, 1'b0, 1, 2'b11, 100000);
        idle(CPB);
        checkOutput("t2_good_data", {8'd0, hsData}, 16'h0039);
        checkOutput("t2_good_fe",   {15'd0, hsFe},  16'd0);
        checkOutput("t2_overrun",   {15'd0, ov0},   16'd0);

        // A 10-cycle low glitch is rejected at the start-bit sample point.
        hsSnap = hsCount;
        @(negedge clk);
        rxLine[0] = 1'b0;
        idle(9);
        rxLine[0] = 1'b1;
        idle(6);
        checkOutput("t3_busy_during", {15'd0, busy0}, 16'd1);
        idle(20);
        checkOutput("t3_busy_after",  {15'd0, busy0}, 16'd0);
        checkOutput("t3_no_word",     16'(hsCount - hsSnap), 16'd0);

        // Back-to-back frames with the consumer stalled for the first two.
        readyLine[0] = 1'b0;
        hsSnap = hsCount;
        applyStimulus(0, 9'h038, 8, 0, 1'b0, 1, 2'b11, 100000);
        applyStimulus(0, 9'h037, 8, 0, 1'b0, 1, 2'b11, 100000);
        checkOutput("t4_held_data",  {8'd0, data0},  16'h0038);
        checkOutput("t4_held_valid", {15'd0, valid0}, 16'd1);
        checkOutput("t4_overrun",    {15'd0, ov0},   16'd1);
        readyLine[0] = 1'b1;
        applyStimulus(0, 9'h02A, 8, 0, 1'b0, 1, 2'b11, 100000);
        applyStimulus(0, 9'h039, 8, 0, 1'b0, 1, 2'b11, 100000);
        applyStimulus(0, 9'h033, 8, 0, 1'b0, 1, 2'b11, 100000);
        idle(CPB);
        checkOutput("t4_hs_count",   16'(hsCount - hsSnap), 16'd4);
        checkOutput("t4_last_data",  {8'd0, hsData}, 16'h0033);
        checkOutput("t4_sticky_ovr", {15'd0, ov0},   16'd1);

        // Even parity: 0x37 has five ones, so a parity bit of 0 is wrong.
        applyStimulus(1, 9'h037, 8, 1, 1'b0, 1, 2'b11, 100000);
        idle(4);
        checkOutput("t5_valid", {15'd0, valid1}, 16'd1);
        checkOutput("t5_data",  {8'd0, data1},   16'h0037);
        checkOutput("t5_pe",    {15'd0, pe1},    16'd1);
        checkOutput("t5_fe",    {15'd0, fe1},    16'd0);
        readyLine[1] = 1'b1;
        idle(1);
        readyLine[1] = 1'b0;
        applyStimulus(1, 9'h038, 8, 1, 1'b1, 1, 2'b11, 100000);
        idle(4);
        checkOutput("t5_good_data", {8'd0, data1}, 16'h0038);
        checkOutput("t5_good_pe",   {15'd0, pe1},  16'd0);

        // Reset during data bit 3 abandons the frame; only 0x33 appears.
        applyStimulus(2, 9'h055, 7, 0, 1'b0, 2, 2'b11, CPB + 3 * CPB + CPB / 2);
        checkOutput("t6_busy_mid", {15'd0, busy2}, 16'd1);
        rstN[2]   = 1'b0;
        rxLine[2] = 1'b1;
        idle(4);
        checkOutput("t6_rst_busy",  {15'd0, busy2},  16'd0);
        rstN[2] = 1'b1;
        idle(3 * CPB);
        checkOutput("t6_no_stale",  {15'd0, valid2}, 16'd0);
        applyStimulus(2, 9'h033, 7, 0, 1'b0, 2, 2'b11, 100000);
        idle(4);
        checkOutput("t6_valid", {15'd0, valid2}, 16'd1);
        checkOutput("t6_data",  {9'd0, data2},   16'h0033);
        checkOutput("t6_fe",    {15'd0, fe2},    16'd0);
        checkOutput("t6_ovr",   {15'd0, ov2},    16'd0);
        readyLine[2] = 1'b1;
        idle(1);
        readyLine[2] = 1'b0;
        idle(1);
        checkOutput("t6_valid_drop", {15'd0, valid2}, 16'd0);

        // Second stop bit low must raise the framing error.
        applyStimulus(2, 9'h04C, 7, 0, 1'b0, 2, 2'b01, 100000);
        idle(4);
        checkOutput("t7_data", {9'd0, data2}, 16'h004C);
        checkOutput("t7_fe",   {15'd0, fe2},  16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
